// File: rtl/alu_digit_serial.sv
// -----------------------------------------------------------------------------
// alu_digit_serial
//   Small-area multi-cycle execute unit. A WIDTH-bit ALU operation is computed
//   DIGIT bits per clock, least-significant digit first. A carry register links
//   consecutive digits. Valid/ready handshakes are used on both the operand side
//   and the result side.
//
//   Control encoding (3-bit, 1-bit-ALU-slice style):
//     bit 2 selects the logic unit; bit 0 inverts B and seeds the carry-in.
//     2=ADD 3=SUB 4=AND 5=OR 6=NOR 7=XOR, 0 undefined.
//     1=SLT only when ALU_SLT_EN is defined; otherwise 1 is undefined.
//     An undefined code gives out=0 and zero=1, with the normal latency.
//
//   Optional feature macro: ALU_SLT_EN (signed set-less-than on control=1).
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operands/control valid        in_ready  accepting (IDLE only)
//   A, B       WIDTH-bit operands            control   3-bit op code
//   out_valid  result valid (DONE)           out_ready consumer takes result
//   out        WIDTH-bit result
//   carryout   carry out of MSB (arith only) overflow  signed overflow (arith only)
//   zero       out == 0                      negative  out[WIDTH-1]
//   All result outputs read as 0 unless out_valid is high.
// -----------------------------------------------------------------------------
module alu_digit_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("alu_digit_serial: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       ctrl_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q, ovf_q;

  logic             accept, last_dig;
  logic             is_addsub, is_slt, is_arith;
  logic [DIGIT-1:0] a_dig, b_eff, logic_dig, res_dig;
  logic [DIGIT:0]   sum_full;
  logic             c_msb_in, dig_ovf;
  logic [WIDTH-1:0] res_shifted;

  assign accept   = in_valid & in_ready_q & (state_q == S_IDLE);
  assign last_dig = (cnt_q == CW'(NDIG - 1));

  assign is_addsub = (ctrl_q == 3'd2) | (ctrl_q == 3'd3);
`ifdef ALU_SLT_EN
  assign is_slt = (ctrl_q == 3'd1);
`else
  assign is_slt = 1'b0;
`endif
  assign is_arith = is_addsub | is_slt;

  // Digit slice: adder with optional B inversion plus the bitwise logic unit.
  always_comb begin
    a_dig    = a_q[DIGIT-1:0];
    b_eff    = b_q[DIGIT-1:0] ^ {DIGIT{ctrl_q[0]}};
    sum_full = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of the digit, recovered from that bit's sum.
    c_msb_in = sum_full[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_eff[DIGIT-1];
    dig_ovf  = c_msb_in ^ sum_full[DIGIT];
    case (ctrl_q[1:0])
      2'b00:   logic_dig = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
      2'b01:   logic_dig = a_q[DIGIT-1:0] | b_q[DIGIT-1:0];
      2'b10:   logic_dig = ~(a_q[DIGIT-1:0] | b_q[DIGIT-1:0]);
      default: logic_dig = a_q[DIGIT-1:0] ^ b_q[DIGIT-1:0];
    endcase
    if (is_arith)       res_dig = sum_full[DIGIT-1:0];
    else if (ctrl_q[2]) res_dig = logic_dig;
    else                res_dig = '0;
    // New digit enters at the top; after NDIG steps the result is aligned.
    res_shifted = (res_q >> DIGIT) | (WIDTH'(res_dig) << (WIDTH - DIGIT));
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last_dig) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready is registered so it stays low throughout reset and only rises
  // on the first edge after release (and the cycle after a result handshake).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) in_ready_q <= 1'b0;
    else          in_ready_q <= (state_d == S_IDLE);
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ctrl_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= B;
            ctrl_q  <= control;
            carry_q <= control[0];
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= sum_full[DIGIT];
          if (last_dig) begin
            cnt_q  <= '0;
            cout_q <= is_addsub & sum_full[DIGIT];
            ovf_q  <= is_addsub & dig_ovf;
            // SLT: sign of the difference corrected by its overflow.
            if (is_slt) res_q <= WIDTH'(res_dig[DIGIT-1] ^ dig_ovf);
            else        res_q <= res_shifted;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            res_q <= res_shifted;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: result and flags are only visible while the result is valid.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q == S_DONE);
    out       = out_valid ? res_q : '0;
    carryout  = out_valid & cout_q;
    overflow  = out_valid & ovf_q;
    zero      = out_valid & (res_q == '0);
    negative  = out_valid & res_q[WIDTH-1];
  end

endmodule

// File: tb/tb_alu_digit_serial.sv
// -----------------------------------------------------------------------------
// tb_alu_digit_serial
//   Three instances (DIGIT = 4, 1, 32) share one stimulus stream. Each issued
//   operation pushes its hand-computed result into one queue per instance; a
//   per-instance monitor checks latency when out_valid rises and pops/compares
//   the result on each output handshake.
// -----------------------------------------------------------------------------
module tb_alu_digit_serial;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  control = '0;

  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [31:0] out_w       [3];
  logic        cout_w      [3];
  logic        ovf_w       [3];
  logic        zero_w      [3];
  logic        neg_w       [3];

  typedef struct {
    logic [31:0] out;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        co;
    logic        ov;
  } vec_t;

  exp_t sb [3][$];
  vec_t vecs [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic all_ready();
    return in_ready_w[0] & in_ready_w[1] & in_ready_w[2];
  endfunction

  task automatic push_exp(input logic [31:0] r, input logic co, input logic ov, input int acc);
    exp_t e;
    e.out = r; e.cout = co; e.ovf = ov; e.acc = acc;
    for (int i = 0; i < 3; i++) sb[i].push_back(e);
  endtask

  // Waits for all units idle, issues one operation, returns one cycle after accept.
  task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic co, input logic ov);
    int t;
    t = 0;
    while (!all_ready() && t < 500) begin
      @(posedge clock); #1;
      t++;
    end
    check("send_ready_timeout", {63'd0, all_ready()}, 64'd1);
    A = a; B = b; control = c; in_valid = 1'b1;
    push_exp(r, co, ov, cyc + 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && t < 500) begin
      @(posedge clock); #1;
      t++;
    end
    check("drain_timeout", 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_i%0d_outs", tag, i),
            {25'd0, in_ready_w[i], out_valid_w[i], cout_w[i], ovf_w[i], zero_w[i], neg_w[i], out_w[i]},
            64'd0);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int DG = (gi == 0) ? 4 : ((gi == 1) ? 1 : 32);

      alu_digit_serial #(.WIDTH(32), .DIGIT(DG)) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready_w[gi]),
        .A        (A),
        .B        (B),
        .control  (control),
        .out_valid(out_valid_w[gi]),
        .out_ready(out_ready),
        .out      (out_w[gi]),
        .carryout (cout_w[gi]),
        .overflow (ovf_w[gi]),
        .zero     (zero_w[gi]),
        .negative (neg_w[gi])
      );

      initial begin : monitor
        logic vprev;
        exp_t e;
        vprev = 1'b0;
        forever begin
          @(negedge clock);
          if (out_valid_w[gi] && !vprev) begin
            if (sb[gi].size() == 0) check($sformatf("d%0d_unexpected_valid", DG), 64'd1, 64'd0);
            else check($sformatf("d%0d_latency", DG), 64'(cyc - sb[gi][0].acc), 64'(DG == 4 ? 8 : (DG == 1 ? 32 : 1)));
          end
          if (out_valid_w[gi] && out_ready && sb[gi].size() != 0) begin
            e = sb[gi].pop_front();
            $display("txn DIGIT=%0d out=%h cout=%0d ovf=%0d zero=%0d neg=%0d (expect %h)",
                     DG, out_w[gi], cout_w[gi], ovf_w[gi], zero_w[gi], neg_w[gi], e.out);
            check($sformatf("d%0d_out", DG), 64'(out_w[gi]), 64'(e.out));
            check($sformatf("d%0d_carryout", DG), 64'(cout_w[gi]), 64'(e.cout));
            check($sformatf("d%0d_overflow", DG), 64'(ovf_w[gi]), 64'(e.ovf));
            check($sformatf("d%0d_zero", DG), 64'(zero_w[gi]), 64'(e.out == 32'd0));
            check($sformatf("d%0d_negative", DG), 64'(neg_w[gi]), 64'(e.out[31]));
          end
          vprev = out_valid_w[gi];
        end
      end
    end
  endgenerate

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Directed vectors: control, A, B, expected out, carryout, overflow.
    vecs.push_back('{3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{3'd3, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{3'd3, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{3'd3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1});
    vecs.push_back('{3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
    vecs.push_back('{3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0});
    vecs.push_back('{3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0});
    vecs.push_back('{3'd0, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0});
`ifdef ALU_SLT_EN
    vecs.push_back('{3'd1, 32'hFFFFFFFD, 32'h00000002, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0});
`else
    vecs.push_back('{3'd1, 32'h00000009, 32'h00000002, 32'h00000000, 1'b0, 1'b0});
`endif

    // Reset state (asserted, before any clock edge).
    #1;
    check_all_zero("reset");
    #21;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("ready_after_reset", {63'd0, all_ready()}, 64'd1);

    foreach (vecs[k]) begin
      send(vecs[k].c, vecs[k].a, vecs[k].b, vecs[k].r, vecs[k].co, vecs[k].ov);
      drain();
    end

    // Backpressure: result held in DONE while a new op waits on in_valid.
    out_ready = 1'b0;
    send(3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    repeat (40) @(posedge clock);
    #1;
    A = 32'd3; B = 32'd4; control = 3'd2; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("hold_i%0d_out", i), 64'(out_w[i]), 64'h80000000);
        check($sformatf("hold_i%0d_flags", i),
              {59'd0, out_valid_w[i], in_ready_w[i], ovf_w[i], cout_w[i], neg_w[i]}, 64'b10101);
      end
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    push_exp(32'd7, 1'b0, 1'b0, cyc + 2);
    @(posedge clock);
    @(posedge clock); #1;
    in_valid = 1'b0;
    drain();

    // Reset in the middle of RUN discards the operation.
    send(3'd2, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    for (int i = 0; i < 3; i++) sb[i].delete();
    #10;
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("release_i%0d_in_ready", i), 64'(in_ready_w[i]), 64'd0);
    @(posedge clock); #1;
    check("ready_after_release", {63'd0, all_ready()}, 64'd1);
    send(3'd2, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
    drain();

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
